// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer
// Paces the serial ADC receiver at a fixed sample rate. Each sample period it pulses
// adc_inicio_rx, waits for the receiver's done level, and captures the 12-bit word.
// The captured word goes into a one-entry valid/ready output register. Overruns and
// conversion timeouts are flagged.
//
// state     | meaning
// ----------+------------------------------------------------------------------
// IDLE      | sampling stopped; tick counter held at 0
// WAIT_TICK | waiting for the next sample-rate tick
// START     | adc_inicio_rx held high for START_LEN cycles
// WAIT_DONE | waiting for the synced done edge; aborts after TIMEOUT_CYC cycles
module adc_sample_sequencer #(
  parameter int SAMPLE_DIV  = 2268,
  parameter int START_LEN   = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_rx_listo,
  input  logic [11:0] adc_paquete_bits,
  output logic        adc_inicio_rx,
  output logic [11:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [7:0]  overrun_cnt,
  output logic        timeout_err,
  output logic        busy
);

  localparam int TICK_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PHASE_MAX = (START_LEN > TIMEOUT_CYC) ? START_LEN : TIMEOUT_CYC;
  localparam int PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST    = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [PHASE_W-1:0] START_LOAD   = PHASE_W'(START_LEN - 1);
  localparam logic [PHASE_W-1:0] TIMEOUT_LOAD = PHASE_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [PHASE_W-1:0] phase_cnt, phase_nxt;
  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic               listo_s1, listo_s2, listo_s3;
  logic               done_pulse;
  logic               capture;
  logic               timeout_hit;
  logic               overrun_evt;

  // The receiver's done level comes from the divided ADC clock, so it is resynchronized
  // here. The third flop holds the previous synced level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      listo_s1 <= 1'b0;
      listo_s2 <= 1'b0;
      listo_s3 <= 1'b0;
    end else begin
      listo_s1 <= adc_rx_listo;
      listo_s2 <= listo_s1;
      listo_s3 <= listo_s2;
    end
  end

  assign done_pulse = listo_s2 & ~listo_s3;

  // Sample-rate divider: free-runs while enabled and is cleared whenever sampling stops.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign tick = enable && (tick_cnt == TICK_LAST);

  // Register for the state and the shared phase timer (start-pulse length, then timeout).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_nxt;
    end
  end

  // Next-state logic. Dropping enable overrides everything and aborts a conversion in flight.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase_cnt;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = WAIT_TICK;
        end
        WAIT_TICK: begin
          if (tick) begin
            state_nxt = START;
            phase_nxt = START_LOAD;
          end
        end
        START: begin
          if (phase_cnt == '0) begin
            state_nxt = WAIT_DONE;
            phase_nxt = TIMEOUT_LOAD;
          end else begin
            phase_nxt = phase_cnt - PHASE_W'(1);
          end
        end
        WAIT_DONE: begin
          if (done_pulse) begin
            capture   = 1'b1;
            state_nxt = WAIT_TICK;
          end else if (phase_cnt == '0) begin
            timeout_hit = 1'b1;
            state_nxt   = WAIT_TICK;
          end else begin
            phase_nxt = phase_cnt - PHASE_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign adc_inicio_rx = (state == START);
  assign busy          = (state == START) || (state == WAIT_DONE);

  // A tick that lands while a conversion is still running is dropped and counted,
  // as is a capture that overwrites an unconsumed sample. Both together count once.
  assign overrun_evt = (capture && sample_valid && !sample_ready) || (tick && busy);

  // Output slot and status flags. A new capture takes priority over the consumer's accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun_cnt  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (capture) begin
        sample_data  <= adc_paquete_bits;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (overrun_evt && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
